// File: rtl/dense_pkg.sv
// dense_pkg: shared state encoding and width/saturation helpers for the
// time-multiplexed dense layer (dense_layer_seq, dense_mac_unit).
package dense_pkg;

   // FSM state encoding, exported on the dbg_state port of dense_layer_seq.
   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_LOAD  = 3'd1;
   localparam state_t ST_MAC   = 3'd2;
   localparam state_t ST_STORE = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Accumulator width large enough that bias + N_IN products never wrap.
   function automatic int acc_width(input int a_bits, input int w_bits,
                                    input int b_bits, input int n_in);
      int p;
      p = a_bits + w_bits + $clog2(n_in);
      return ((p > b_bits) ? p : b_bits) + 1;
   endfunction

   // Clamp v to the signed range of an out_bits-wide result.
   function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int out_bits);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_bits - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dense_layer_seq_mac.sv
// dense_mac_unit: accumulator for one neuron. LOAD seeds it with the
// sign-extended bias, MAC adds one signed weight*activation product per
// cycle, and result_o presents the saturated (optionally ReLU-clamped)
// value for the STORE cycle.
module dense_mac_unit
   import dense_pkg::*;
#(
   parameter int N_IN     = 48,
   parameter int A_BITS   = 2,
   parameter int W_BITS   = 2,
   parameter int B_BITS   = 4,
   parameter int OUT_BITS = 6,
   parameter int RELU     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_i,
   input  logic                       mac_en_i,
   input  logic signed [B_BITS-1:0]   bias_i,
   input  logic signed [W_BITS-1:0]   weight_i,
   input  logic signed [A_BITS-1:0]   act_i,
   output logic signed [OUT_BITS-1:0] result_o
);

   localparam int ACC_W = acc_width(A_BITS, W_BITS, B_BITS, N_IN);
   localparam int P_W   = A_BITS + W_BITS;

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [P_W-1:0]   prod;
   logic signed [63:0]      sat_v;

   // Next accumulator value: bias load has priority over accumulate.
   always_comb begin
      prod  = P_W'(act_i) * P_W'(weight_i);
      acc_d = acc_q;
      if (load_i) begin
         acc_d = ACC_W'(bias_i);
      end else if (mac_en_i) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   // Accumulator register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   // Saturate to the stored width, then optionally clamp negatives to zero.
   always_comb begin
      sat_v = sat_signed(64'(acc_q), OUT_BITS);
      if ((RELU != 0) && (sat_v < 0)) begin
         sat_v = '0;
      end
      result_o = OUT_BITS'(sat_v);
   end

endmodule

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: time-multiplexed fully-connected layer. Activations are
// snapshotted on an accepted start, then each neuron runs LOAD (bias),
// N_IN MAC cycles and STORE through one shared dense_mac_unit. Results sit
// in a random-access buffer. Optional feature macro: DENSE_ARGMAX_EN builds
// the argmax_idx/argmax_val ports and the running-maximum tracker.
// ROM contents come from the W_INIT/B_INIT parameter images.
module dense_layer_seq
  import dense_pkg::*;
#(
  parameter int    N_IN     = 48,
  parameter int    N_OUT    = 10,
  parameter int    A_BITS   = 2,
  parameter int    W_BITS   = 2,
  parameter int    B_BITS   = 4,
  parameter int    OUT_BITS = 6,
  parameter int    RELU     = 0,
  parameter string W_FILE   = "layer2_weights.hex",
  parameter string B_FILE   = "layer2_biases.hex",
  parameter logic [N_OUT*N_IN*W_BITS-1:0] W_INIT = '0,
  parameter logic [N_OUT*B_BITS-1:0]      B_INIT = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_IN*A_BITS-1:0]        act_flat,
  output logic                          busy,
  output logic                          done,
  input  logic [clog2_min1(N_OUT)-1:0]  read_addr,
  output logic signed [OUT_BITS-1:0]    read_data,
`ifdef DENSE_ARGMAX_EN
  output logic [clog2_min1(N_OUT)-1:0]  argmax_idx,
  output logic signed [OUT_BITS-1:0]    argmax_val,
`endif
  output state_t                        dbg_state
);

  localparam int IDX_W = clog2_min1(N_OUT);
  localparam int I_W   = clog2_min1(N_IN);
  localparam int WA_W  = clog2_min1(N_OUT * N_IN);

  logic signed [W_BITS-1:0]   w_rom [N_OUT*N_IN];
  logic signed [B_BITS-1:0]   b_rom [N_OUT];
  logic signed [A_BITS-1:0]   act_q [N_IN];
  logic signed [OUT_BITS-1:0] res_q [N_OUT];

  state_t           state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [I_W-1:0]   i_q, i_d;
  logic [WA_W-1:0]  wa_q, wa_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept, load, mac_en, store;
  logic signed [OUT_BITS-1:0] mac_result;

  // ROM images from the parameter defaults.
  initial begin
    for (int k = 0; k < N_OUT*N_IN; k++) w_rom[k] = W_INIT[k*W_BITS +: W_BITS];
    for (int k = 0; k < N_OUT; k++) b_rom[k] = B_INIT[k*B_BITS +: B_BITS];
  end

  // FSM next state; wa walks the neuron-major weight ROM linearly.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    wa_d    = wa_q;
    busy_d  = busy_q;
    done_d  = done_q;
    accept  = 1'b0;
    load    = 1'b0;
    mac_en  = 1'b0;
    store   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          n_d     = '0;
          wa_d    = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        i_d     = '0;
        state_d = ST_MAC;
      end
      ST_MAC: begin
        mac_en = 1'b1;
        wa_d   = wa_q + WA_W'(1);
        if (i_q == I_W'(N_IN - 1)) begin
          state_d = ST_STORE;
        end else begin
          i_d = i_q + I_W'(1);
        end
      end
      ST_STORE: begin
        store = 1'b1;
        if (n_q == IDX_W'(N_OUT - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          n_d     = n_q + IDX_W'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        if (!start) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      i_q     <= '0;
      wa_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
      wa_q    <= wa_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Activation snapshot; later act_flat changes are invisible to the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_IN; k++) act_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < N_IN; k++) act_q[k] <= act_flat[k*A_BITS +: A_BITS];
    end
  end

  dense_mac_unit #(
    .N_IN     (N_IN),
    .A_BITS   (A_BITS),
    .W_BITS   (W_BITS),
    .B_BITS   (B_BITS),
    .OUT_BITS (OUT_BITS),
    .RELU     (RELU)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load),
    .mac_en_i (mac_en),
    .bias_i   (b_rom[n_q]),
    .weight_i (w_rom[wa_q]),
    .act_i    (act_q[i_q]),
    .result_o (mac_result)
  );

  // Result buffer, one entry written per STORE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
    end else if (store) begin
      res_q[n_q] <= mac_result;
    end
  end

  // Combinational readout; out-of-range addresses read as zero.
  always_comb begin
    read_data = '0;
    if (32'(read_addr) < N_OUT) read_data = res_q[read_addr];
  end

`ifdef DENSE_ARGMAX_EN
  localparam logic signed [OUT_BITS-1:0] MOST_NEG = {1'b1, {(OUT_BITS-1){1'b0}}};

  logic [IDX_W-1:0]           am_idx_q;
  logic signed [OUT_BITS-1:0] am_val_q;

  // Running maximum; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      am_idx_q <= '0;
      am_val_q <= '0;
    end else if (load && (n_q == '0)) begin
      am_idx_q <= '0;
      am_val_q <= MOST_NEG;
    end else if (store && (mac_result > am_val_q)) begin
      am_idx_q <= n_q;
      am_val_q <= mac_result;
    end
  end

  assign argmax_idx = am_idx_q;
  assign argmax_val = am_val_q;
`else
  // Argmax tracker not built in this configuration.
`endif

  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: three small dense_layer_seq instances sharing clock,
// reset and start. dut_a is the 4x3 classifier case, dut_s exercises
// saturation at OUT_BITS=3, dut_r exercises ReLU with all-negative sums.
module tb_dense_layer_seq;
   import dense_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   logic start;

   initial forever #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- DUT signals ----------------
   logic [7:0]        act_a, act_s, act_r;
   logic              busy_a, done_a, busy_s, done_s, busy_r, done_r;
   logic [1:0]        raddr_a, raddr_r;
   logic [0:0]        raddr_s;
   logic signed [5:0] rdata_a, rdata_r;
   logic signed [2:0] rdata_s;
   state_t            st_a, st_s, st_r;
`ifdef DENSE_ARGMAX_EN
   logic [1:0]        amidx_a, amidx_r;
   logic [0:0]        amidx_s;
   logic signed [5:0] amval_a, amval_r;
   logic signed [2:0] amval_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   logic signed [31:0] exp_q[$];

   dense_layer_seq #(
      .N_IN(4), .N_OUT(3), .A_BITS(2), .W_BITS(2), .B_BITS(4), .OUT_BITS(6), .RELU(0),
      .W_FILE(""), .B_FILE(""), .W_INIT(24'h555555), .B_INIT(12'hF10)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start), .act_flat(act_a),
      .busy(busy_a), .done(done_a), .read_addr(raddr_a), .read_data(rdata_a),
`ifdef DENSE_ARGMAX_EN
      .argmax_idx(amidx_a), .argmax_val(amval_a),
`endif
      .dbg_state(st_a)
   );

   dense_layer_seq #(
      .N_IN(4), .N_OUT(2), .A_BITS(2), .W_BITS(2), .B_BITS(4), .OUT_BITS(3), .RELU(0),
      .W_FILE(""), .B_FILE(""), .W_INIT(16'hFF55), .B_INIT(8'h87)
   ) dut_s (
      .clk(clk), .rst(rst), .start(start), .act_flat(act_s),
      .busy(busy_s), .done(done_s), .read_addr(raddr_s), .read_data(rdata_s),
`ifdef DENSE_ARGMAX_EN
      .argmax_idx(amidx_s), .argmax_val(amval_s),
`endif
      .dbg_state(st_s)
   );

   dense_layer_seq #(
      .N_IN(4), .N_OUT(3), .A_BITS(2), .W_BITS(2), .B_BITS(4), .OUT_BITS(6), .RELU(1),
      .W_FILE(""), .B_FILE(""), .W_INIT(24'hFFFFFF), .B_INIT(12'hEF0)
   ) dut_r (
      .clk(clk), .rst(rst), .start(start), .act_flat(act_r),
      .busy(busy_r), .done(done_r), .read_addr(raddr_r), .read_data(rdata_r),
`ifdef DENSE_ARGMAX_EN
      .argmax_idx(amidx_r), .argmax_val(amval_r),
`endif
      .dbg_state(st_r)
   );

   // ---------------- driver tasks / scoreboard ----------------
   task automatic check(input string name, input logic signed [31:0] got,
                        input logic signed [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present start for one edge (the acceptance edge, cycle 0).
   task automatic do_start(input bit hold);
      start = 1'b1;
      tick();
      if (!hold) start = 1'b0;
   endtask

   // Called in cycle 1; waits for done on dut_a with a cycle budget.
   // At poke_cyc it rewrites act_a and pulses start while the run is busy.
   task automatic run_to_done(input string name, input int want_cyc,
                              input int poke_cyc, input logic [7:0] poke_act);
      int cyc, busy_cnt, first_busy;
      cyc = 1;
      busy_cnt = 0;
      first_busy = -1;
      while ((done_a !== 1'b1) && (cyc < 200)) begin
         if (busy_a === 1'b1) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
         end
         if (cyc == poke_cyc) begin
            act_a = poke_act;
            start = 1'b1;
         end
         if (cyc == poke_cyc + 1) start = 1'b0;
         tick();
         cyc++;
      end
      check({name, "_done_cycle"}, cyc, want_cyc);
      check({name, "_busy_cycles"}, busy_cnt, want_cyc - 1);
      check({name, "_busy_first"}, first_busy, 1);
      check({name, "_busy_low_at_done"}, busy_a, 0);
   endtask

   task automatic expect_a(input string name, input int e0, input int e1, input int e2);
      exp_q.push_back(e0);
      exp_q.push_back(e1);
      exp_q.push_back(e2);
      for (int k = 0; k < 3; k++) begin
         raddr_a = 2'(k);
         #1;
         check($sformatf("%s_res%0d", name, k), rdata_a, exp_q.pop_front());
      end
   endtask

   // ---------------- read-back vector table ----------------
   typedef struct {
      int    sel;
      int    addr;
      int    exp_val;
      string name;
   } rd_vec_t;

   rd_vec_t vecs[9];

   // ---------------- test sequence ----------------
   initial begin
      logic signed [31:0] got;
      int extra_busy, done_low;

      vecs[0] = '{0, 0,  2, "a_res0"};
      vecs[1] = '{0, 1,  3, "a_res1"};
      vecs[2] = '{0, 2,  1, "a_res2"};
      vecs[3] = '{0, 3,  0, "a_out_of_range"};
      vecs[4] = '{1, 0,  3, "sat_pos"};
      vecs[5] = '{1, 1, -4, "sat_neg"};
      vecs[6] = '{2, 0,  0, "relu0"};
      vecs[7] = '{2, 1,  0, "relu1"};
      vecs[8] = '{2, 2,  0, "relu2"};

      rst = 1'b1;
      start = 1'b0;
      act_a = 8'hD5;   // {-1, 1, 1, 1}
      act_s = 8'h55;   // all +1
      act_r = 8'h55;
      raddr_a = '0;
      raddr_s = '0;
      raddr_r = '0;
      #1;
      check("reset_busy", busy_a, 0);
      check("reset_done", done_a, 0);
      check("reset_state", st_a, ST_IDLE);
      check("reset_read", rdata_a, 0);
      tick();
      tick();
      rst = 1'b0;

      // Run 1: nominal.
      do_start(1'b0);
      check("run1_done_cleared", done_a, 0);
      run_to_done("run1", 19, -1, 8'h00);

      foreach (vecs[v]) begin
         case (vecs[v].sel)
            0: begin raddr_a = 2'(vecs[v].addr); #1; got = rdata_a; end
            1: begin raddr_s = 1'(vecs[v].addr); #1; got = rdata_s; end
            default: begin raddr_r = 2'(vecs[v].addr); #1; got = rdata_r; end
         endcase
         check(vecs[v].name, got, vecs[v].exp_val);
      end
`ifdef DENSE_ARGMAX_EN
      check("a_argmax_idx", amidx_a, 1);
      check("a_argmax_val", amval_a, 3);
      check("s_argmax_idx", amidx_s, 0);
      check("s_argmax_val", amval_s, 3);
      check("r_argmax_idx", amidx_r, 0);
      check("r_argmax_val", amval_r, 0);
`endif

      // Run 2: act_flat changed and start pulsed mid-run must be ignored.
      tick();
      do_start(1'b0);
      check("run2_done_cleared", done_a, 0);
      run_to_done("run2", 19, 5, 8'hFF);
      expect_a("run2", 2, 3, 1);
      act_a = 8'hD5;

      // Run 3: start held through completion gives exactly one run.
      tick();
      do_start(1'b1);
      run_to_done("run3", 19, -1, 8'h00);
      act_a = 8'h55;
      extra_busy = 0;
      done_low = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (busy_a !== 1'b0) extra_busy++;
         if (done_a !== 1'b1) done_low++;
      end
      check("hold_no_rerun_busy", extra_busy, 0);
      check("hold_done_kept", done_low, 0);
      expect_a("run3", 2, 3, 1);

      // Run 4: drop then raise start; the new snapshot is all +1.
      start = 1'b0;
      tick();
      do_start(1'b0);
      check("run4_done_falls", done_a, 0);
      check("run4_busy_rises", busy_a, 1);
      run_to_done("run4", 19, -1, 8'h00);
      expect_a("run4", 4, 5, 3);
`ifdef DENSE_ARGMAX_EN
      check("run4_argmax_idx", amidx_a, 1);
      check("run4_argmax_val", amval_a, 5);
`endif

      // Run 5: asynchronous reset at cycle 7 abandons the run.
      tick();
      act_a = 8'hD5;
      do_start(1'b0);
      repeat (6) tick();
      rst = 1'b1;
      #1;
      check("midrst_busy", busy_a, 0);
      check("midrst_done", done_a, 0);
      check("midrst_state", st_a, ST_IDLE);
      expect_a("midrst", 0, 0, 0);
`ifdef DENSE_ARGMAX_EN
      check("midrst_argmax_idx", amidx_a, 0);
      check("midrst_argmax_val", amval_a, 0);
`endif
      tick();
      rst = 1'b0;
      do_start(1'b0);
      run_to_done("run6", 19, -1, 8'h00);
      expect_a("run6", 2, 3, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
